// File: rtl/visuaudio_pkg.sv
// Shared visualiser types: band count, level width and meter state encoding.
// Imported by the band level meter and by beat detection.
package visuaudio_pkg;

    localparam int NUM_BANDS = 3;
    localparam int LEVEL_W   = 4;
    localparam int ACC_W     = 22;
    localparam int LEVEL_MAX = (1 << LEVEL_W) - 1;

    typedef logic [LEVEL_W-1:0] level_t;
    typedef level_t [NUM_BANDS-1:0] band_levels_t;

    typedef enum logic [1:0] {
        ST_ACCUM,
        ST_ENC0,
        ST_ENC1,
        ST_ENC2
    } meter_state_t;

endpackage

// File: rtl/band_level_encode.sv
// Log2-style level encoder: msb position of a band sum, offset and clamped.
// Purely combinational; shared across the three bands by the meter.
module band_level_encode
    import visuaudio_pkg::*;
#(
    parameter int LOG_OFFSET = 6
) (
    input  logic [ACC_W-1:0] acc,
    output level_t           level
);

    logic [4:0] msb;
    int         raw;

    always_comb begin
        msb = '0;
        for (int i = 0; i < ACC_W; i++) begin
            if (acc[i]) msb = 5'(i);
        end
        raw = int'(msb) + 1 - LOG_OFFSET;
        if (acc == '0 || raw < 0) begin
            level = '0;
        end else if (raw > LEVEL_MAX) begin
            level = level_t'(LEVEL_MAX);
        end else begin
            level = level_t'(raw);
        end
    end

endmodule

// File: rtl/band_level_meter.sv
// Per-frame three-band level meter: sums bin magnitudes per band, then
// encodes each band in turn and publishes all levels together.
module band_level_meter
    import visuaudio_pkg::*;
#(
    parameter int NUM_BINS   = 64,
    parameter int B0_END     = 3,
    parameter int B1_END     = 15,
    parameter int LOG_OFFSET = 6,
    parameter int DECAY_EN   = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_bin_valid,
    output logic         o_bin_ready,
    input  logic [15:0]  i_bin_mag,
    input  logic         i_bin_last,
    output band_levels_t o_level,
    output logic         o_frame_valid,
    output logic         o_overrun
);

    localparam int IDX_W = $clog2(NUM_BINS) + 1;
    localparam logic [IDX_W-1:0] B0_E = IDX_W'(B0_END);
    localparam logic [IDX_W-1:0] B1_E = IDX_W'(B1_END);
    localparam logic [IDX_W-1:0] N_B  = IDX_W'(NUM_BINS);

    meter_state_t state;
    meter_state_t state_nxt;

    logic [IDX_W-1:0]                bin_idx;
    logic [NUM_BANDS-1:0][ACC_W-1:0] acc;
    band_levels_t                    lvl;
    band_levels_t                    held;
    logic                            commit;
    logic                            frame_valid;

    logic             xfer;
    logic             band_hit;
    logic [1:0]       band_sel;
    logic             enc_act;
    logic [1:0]       enc_sel;
    logic [ACC_W-1:0] enc_in;
    level_t           enc_out;

    function automatic logic [ACC_W-1:0] sat_add(
        input logic [ACC_W-1:0] a,
        input logic [15:0]      m
    );
        logic [ACC_W:0] s;
        s = {1'b0, a} + (ACC_W+1)'(m);
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    assign o_bin_ready   = (state == ST_ACCUM);
    assign xfer          = i_bin_valid & o_bin_ready;
    assign o_overrun     = i_bin_valid & ~o_bin_ready;
    assign o_level       = held;
    assign o_frame_valid = frame_valid;

    always_comb begin
        band_hit = (bin_idx < N_B);
        band_sel = 2'd2;
        if (bin_idx <= B0_E) begin
            band_sel = 2'd0;
        end else if (bin_idx <= B1_E) begin
            band_sel = 2'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= ST_ACCUM;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        enc_act   = 1'b0;
        enc_sel   = 2'd0;
        enc_in    = '0;
        unique case (state)
            ST_ACCUM: begin
                if (xfer && i_bin_last) state_nxt = ST_ENC0;
            end
            ST_ENC0: begin
                enc_act   = 1'b1;
                enc_sel   = 2'd0;
                enc_in    = acc[0];
                state_nxt = ST_ENC1;
            end
            ST_ENC1: begin
                enc_act   = 1'b1;
                enc_sel   = 2'd1;
                enc_in    = acc[1];
                state_nxt = ST_ENC2;
            end
            ST_ENC2: begin
                enc_act   = 1'b1;
                enc_sel   = 2'd2;
                enc_in    = acc[2];
                state_nxt = ST_ACCUM;
            end
            default: state_nxt = ST_ACCUM;
        endcase
    end

    band_level_encode #(
        .LOG_OFFSET(LOG_OFFSET)
    ) u_enc (
        .acc  (enc_in),
        .level(enc_out)
    );

    // Sums and index are wiped as the FSM leaves ENC2 so the next frame starts empty.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bin_idx <= '0;
            acc     <= '0;
        end else if (state == ST_ENC2) begin
            bin_idx <= '0;
            acc     <= '0;
        end else if (xfer) begin
            if (bin_idx != N_B) bin_idx <= bin_idx + 1'b1;
            for (int b = 0; b < NUM_BANDS; b++) begin
                if (band_hit && band_sel == 2'(b)) begin
                    acc[b] <= sat_add(acc[b], i_bin_mag);
                end
            end
        end
    end

    // Levels are staged per band, then committed together one edge after ENC2.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lvl         <= '0;
            held        <= '0;
            commit      <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            commit      <= (state == ST_ENC2);
            frame_valid <= commit;
            for (int b = 0; b < NUM_BANDS; b++) begin
                if (enc_act && enc_sel == 2'(b)) lvl[b] <= enc_out;
            end
            if (commit) begin
                for (int b = 0; b < NUM_BANDS; b++) begin
                    if (DECAY_EN == 0 || lvl[b] >= held[b]) begin
                        held[b] <= lvl[b];
                    end else begin
                        held[b] <= held[b] - 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_band_level_meter.sv
// Directed bench for band_level_meter: hand-computed levels, latency,
// decay, overrun dropping and mid-frame reset.
module tb_band_level_meter;
    import visuaudio_pkg::*;

    logic         i_clk;
    logic         i_rst;
    logic         i_bin_valid;
    logic         o_bin_ready;
    logic [15:0]  i_bin_mag;
    logic         i_bin_last;
    band_levels_t o_level;
    logic         o_frame_valid;
    logic         o_overrun;

    int checks;
    int failures;
    int fv_cnt;
    int ovr_cnt;
    int snap;
    logic [15:0] mags [64];

    band_level_meter dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_bin_valid  (i_bin_valid),
        .o_bin_ready  (o_bin_ready),
        .i_bin_mag    (i_bin_mag),
        .i_bin_last   (i_bin_last),
        .o_level      (o_level),
        .o_frame_valid(o_frame_valid),
        .o_overrun    (o_overrun)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (o_frame_valid) fv_cnt <= fv_cnt + 1;
        if (o_overrun)     ovr_cnt <= ovr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < 64; i++) mags[i] = v;
    endtask

    task automatic send_frame(input int n, input bit keep);
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk);
            i_bin_valid = 1'b1;
            i_bin_mag   = mags[i];
            i_bin_last  = (i == n - 1);
        end
        @(posedge i_clk);
        #1;
        if (!keep) begin
            i_bin_valid = 1'b0;
            i_bin_last  = 1'b0;
        end
    endtask

    task automatic wait_frame(input string tag, input logic [11:0] exp);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (!seen && n < 10) begin
            @(posedge i_clk);
            #1;
            n++;
            if (o_frame_valid) seen = 1;
        end
        check({tag, "_lat"}, n, 4);
        check({tag, "_lvl"}, o_level, exp);
        @(posedge i_clk);
        #1;
        check({tag, "_pulse"}, o_frame_valid, 0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        fv_cnt = 0;
        ovr_cnt = 0;
        i_rst = 1'b1;
        i_bin_valid = 1'b0;
        i_bin_mag = '0;
        i_bin_last = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        check("rst_lvl", o_level, 0);
        check("rst_fv", o_frame_valid, 0);
        check("rst_ovr", o_overrun, 0);
        check("rst_rdy", o_bin_ready, 1);

        fill(16'd0);
        snap = fv_cnt;
        send_frame(64, 0);
        wait_frame("zero", 12'h000);
        repeat (3) @(posedge i_clk);
        check("zero_fvcnt", fv_cnt - snap, 1);

        fill(16'd0);
        for (int i = 0; i < 4; i++) mags[i] = 16'd16;
        send_frame(64, 0);
        wait_frame("bass", 12'h001);

        fill(16'hFFFF);
        send_frame(64, 0);
        wait_frame("full", 12'hFEC);
        repeat (5) @(posedge i_clk);
        #1;
        check("hold_lvl", o_level, 12'hFEC);

        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        check("rst2_lvl", o_level, 0);
        @(negedge i_clk);
        i_rst = 1'b0;

        fill(16'd0);
        mags[4] = 16'd20000;
        send_frame(64, 0);
        wait_frame("dec9", 12'h090);
        fill(16'd0);
        send_frame(64, 0);
        wait_frame("dec8", 12'h080);
        send_frame(64, 0);
        wait_frame("dec7", 12'h070);
        send_frame(64, 0);
        wait_frame("dec6", 12'h060);

        fill(16'd0);
        snap = ovr_cnt;
        send_frame(64, 1);
        i_bin_mag = 16'd40000;
        i_bin_last = 1'b0;
        check("ovr_rdy", o_bin_ready, 0);
        check("ovr_flag", o_overrun, 1);
        repeat (3) @(posedge i_clk);
        #1;
        i_bin_valid = 1'b0;
        @(posedge i_clk);
        #1;
        check("ovr_fv", o_frame_valid, 1);
        check("ovr_lvl", o_level, 12'h050);
        check("ovr_cnt", ovr_cnt - snap, 3);
        fill(16'd0);
        for (int i = 0; i < 4; i++) mags[i] = 16'd16;
        send_frame(64, 0);
        wait_frame("drop", 12'h041);

        fill(16'hFFFF);
        send_frame(20, 0);
        i_bin_valid = 1'b1;
        i_bin_mag = 16'hFFFF;
        i_bin_last = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        i_bin_valid = 1'b0;
        check("mid_lvl", o_level, 0);
        snap = fv_cnt;
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (8) @(posedge i_clk);
        check("mid_nofv", fv_cnt - snap, 0);
        fill(16'd0);
        for (int i = 0; i < 4; i++) mags[i] = 16'd16;
        send_frame(64, 0);
        wait_frame("mid_next", 12'h001);

        mags[0] = 16'd1024;
        send_frame(1, 0);
        wait_frame("one_bin", 12'h005);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
